tx_port_mutex_arbiter: RTL and testbench

Arbitrates ownership of the PHY-TX FIFOs among several switching engines. Each engine drives one request mask per forwarding decision. Ownership is granted all-or-nothing, and the winner's write stream is steered onto each owned PHY-TX FIFO. The block sits between the per-RX-port switching engines (requesters) and the per-PHY TX FIFOs (ports). Round-robin order with head-of-line port reservation keeps wide multi-port requests, such as broadcasts, from starving behind narrow ones.

---
 rtl/tx_port_mutex_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tx_port_mutex_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_port_mutex_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_port_mutex_arbiter
// Purpose  : All-or-nothing ownership of PHY-TX FIFOs for switching engines.
//            Round-robin order with a head-of-line port reservation, plus a
//            registered write-stream steering from each owner to its ports.
// Revision : 1.0 - initial release
// ============================================================================
module tx_port_mutex_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_PORT = 4,
    parameter int REQ_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [NUM_REQ*NUM_PORT-1:0] req_mask,
    output logic [NUM_REQ*NUM_PORT-1:0] grant_mask,
    input  logic [8*NUM_REQ-1:0]        req_din,
    input  logic [NUM_REQ-1:0]          req_del,
    input  logic [NUM_REQ*NUM_PORT-1:0] req_wren,
    output logic [8*NUM_PORT-1:0]       port_din,
    output logic [NUM_PORT-1:0]         port_del,
    output logic [NUM_PORT-1:0]         port_wren,
    output logic [NUM_PORT-1:0]         port_busy,
    output logic [REQ_W*NUM_PORT-1:0]   port_owner,
    output logic                        proto_err
);

    localparam logic [REQ_W-1:0] c_LAST_REQ = REQ_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0][NUM_PORT-1:0] w_req;
    logic [NUM_REQ-1:0][NUM_PORT-1:0] w_wren_req;
    logic [NUM_REQ-1:0][NUM_PORT-1:0] r_lock;
    logic [NUM_REQ-1:0][NUM_PORT-1:0] w_busy_others;
    logic [NUM_REQ-1:0]               w_pend;
    logic [NUM_REQ-1:0]               w_viol;
    logic [REQ_W-1:0]                 r_rr_ptr;
    logic [REQ_W-1:0]                 w_rr_next;
    logic [REQ_W-1:0]                 w_scan;
    logic [REQ_W-1:0]                 w_head;
    logic [REQ_W-1:0]                 w_win;
    logic                             w_head_vld;
    logic                             w_win_vld;
    logic                             w_grant;
    logic [NUM_PORT-1:0]              w_resv;
    logic                             r_init;
    logic [8*NUM_PORT-1:0]            w_port_din;
    logic [NUM_PORT-1:0]              w_port_del;
    logic [NUM_PORT-1:0]              w_port_wren;

    assign w_req      = req_mask;
    assign w_wren_req = req_wren;
    assign grant_mask = r_lock;

    // Per-requester status: pending, mask-growth violation, ports held by others
    always_comb begin
        w_pend        = '0;
        w_viol        = '0;
        w_busy_others = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            w_pend[r] = (|w_req[r]) & ~(|r_lock[r]);
            w_viol[r] = (|r_lock[r]) & (|(w_req[r] & ~r_lock[r]));
            for (int k = 0; k < NUM_REQ; k++) begin
                if (k != r) begin
                    w_busy_others[r] = w_busy_others[r] | r_lock[k];
                end
            end
        end
    end

    // Round-robin scan: head is the first pending requester, winner the first
    // one whose ports are neither held by others nor reserved by the head
    always_comb begin
        w_head_vld = 1'b0;
        w_head     = '0;
        w_win_vld  = 1'b0;
        w_win      = '0;
        w_scan     = '0;
        w_resv     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = REQ_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_head_vld && w_pend[w_scan]) begin
                w_head_vld = 1'b1;
                w_head     = w_scan;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = REQ_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            w_resv = (w_scan != w_head) ? w_req[w_head] : '0;
            if (!w_win_vld && w_pend[w_scan] &&
                ((w_req[w_scan] & (w_busy_others[w_scan] | w_resv)) == '0)) begin
                w_win_vld = 1'b1;
                w_win     = w_scan;
            end
        end
    end

    // The cycle right after reset release never grants, so requests seen
    // while reset was asserted are only acted upon one edge later
    assign w_grant   = w_win_vld & ~r_init;
    assign w_rr_next = (w_head == c_LAST_REQ) ? '0 : w_head + 1'b1;

    // Lock state, round-robin pointer and protocol-error pulse
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_lock    <= '0;
            r_rr_ptr  <= '0;
            r_init    <= 1'b1;
            proto_err <= 1'b0;
        end else begin
            r_init    <= 1'b0;
            proto_err <= |w_viol;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (w_grant && (w_win == REQ_W'(r))) begin
                    r_lock[r] <= w_req[r];
                end else begin
                    r_lock[r] <= r_lock[r] & w_req[r];
                end
            end
            // A non-head winner leaves the pointer so the head keeps its reservation
            if (w_grant && (w_win == w_head)) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Decode port ownership and select the owner's write stream for each port
    always_comb begin
        w_port_din  = '0;
        w_port_del  = '0;
        w_port_wren = '0;
        port_busy   = '0;
        port_owner  = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r_lock[r][p]) begin
                    w_port_wren[p]           = w_wren_req[r][p];
                    w_port_din[p*8 +: 8]     = req_din[r*8 +: 8];
                    w_port_del[p]            = req_del[r];
                    port_busy[p]             = 1'b1;
                    port_owner[p*REQ_W +: REQ_W] = REQ_W'(r);
                end
            end
        end
    end

    // One-cycle registered datapath toward the FIFOs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            port_din  <= '0;
            port_del  <= '0;
            port_wren <= '0;
        end else begin
            port_din  <= w_port_din;
            port_del  <= w_port_del;
            port_wren <= w_port_wren;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_port_mutex_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_port_mutex_arbiter
// Purpose  : Self-checking bench for tx_port_mutex_arbiter: directed scenarios
//            with literal expectations plus randomized protocol traffic
//            compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_port_mutex_arbiter;

    localparam int NR = 4;
    localparam int NP = 4;
    localparam int RW = 2;

    logic              clk = 1'b0;
    logic              arst = 1'b0;
    logic [NR*NP-1:0]  req_mask = '0;
    logic [NR*NP-1:0]  req_wren = '0;
    logic [8*NR-1:0]   req_din = '0;
    logic [NR-1:0]     req_del = '0;
    logic [NR*NP-1:0]  grant_mask;
    logic [8*NP-1:0]   port_din;
    logic [NP-1:0]     port_del;
    logic [NP-1:0]     port_wren;
    logic [NP-1:0]     port_busy;
    logic [RW*NP-1:0]  port_owner;
    logic              proto_err;

    int checks = 0;
    int errors = 0;

    tx_port_mutex_arbiter #(.NUM_REQ(NR), .NUM_PORT(NP)) dut (
        .clk(clk), .arst(arst),
        .req_mask(req_mask), .grant_mask(grant_mask),
        .req_din(req_din), .req_del(req_del), .req_wren(req_wren),
        .port_din(port_din), .port_del(port_del), .port_wren(port_wren),
        .port_busy(port_busy), .port_owner(port_owner), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NP-1:0] m_lock [NR];
    int            m_rr;
    bit            m_init;
    logic [7:0]    m_din [NP];
    logic [NP-1:0] m_wren, m_del;
    logic          m_err;
    logic [NP-1:0] mreq [NR];
    logic [NP-1:0] taken;
    int            head, win, own;

    function automatic bit pending(input logic [NP-1:0] rq, input logic [NP-1:0] lk);
        return (rq != 0) && (lk == 0);
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int r = 0; r < NR; r++) m_lock[r] = '0;
            for (int p = 0; p < NP; p++) m_din[p] = '0;
            m_rr = 0; m_init = 1; m_wren = '0; m_del = '0; m_err = 1'b0;
        end else begin
            for (int r = 0; r < NR; r++) mreq[r] = req_mask[r*NP +: NP];
            // outputs follow the owner as of the current (pre-edge) locks
            for (int p = 0; p < NP; p++) begin
                own = -1;
                for (int r = 0; r < NR; r++) if (m_lock[r][p]) own = r;
                if (own >= 0) begin
                    m_din[p]  = req_din[own*8 +: 8];
                    m_wren[p] = req_wren[own*NP + p];
                    m_del[p]  = req_del[own];
                end else begin
                    m_din[p] = '0; m_wren[p] = 1'b0; m_del[p] = 1'b0;
                end
            end
            m_err = 1'b0;
            for (int r = 0; r < NR; r++)
                if (m_lock[r] != 0 && (mreq[r] & ~m_lock[r]) != 0) m_err = 1'b1;
            head = -1; win = -1;
            for (int i = 0; i < NR; i++)
                if (head < 0 && pending(mreq[(m_rr+i)%NR], m_lock[(m_rr+i)%NR])) head = (m_rr+i)%NR;
            for (int i = 0; i < NR; i++) begin
                int r;
                r = (m_rr + i) % NR;
                if (win < 0 && pending(mreq[r], m_lock[r])) begin
                    taken = '0;
                    for (int k = 0; k < NR; k++) if (k != r) taken |= m_lock[k];
                    if (r != head) taken |= mreq[head];
                    if ((mreq[r] & taken) == 0) win = r;
                end
            end
            for (int r = 0; r < NR; r++) m_lock[r] &= mreq[r];
            if (win >= 0 && !m_init) begin
                m_lock[win] = mreq[win];
                if (win == head) m_rr = (head + 1) % NR;
            end
            m_init = 0;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        if (!arst) begin
            logic [NR*NP-1:0] eg;
            logic [NP-1:0]    eb;
            logic [RW*NP-1:0] eo;
            logic [8*NP-1:0]  ed;
            int               nbad, cnt;
            eg = '0; eb = '0; eo = '0; ed = '0; nbad = 0;
            for (int r = 0; r < NR; r++) eg[r*NP +: NP] = m_lock[r];
            for (int p = 0; p < NP; p++) begin
                for (int r = 0; r < NR; r++)
                    if (m_lock[r][p]) begin eb[p] = 1'b1; eo[p*RW +: RW] = RW'(r); end
                ed[p*8 +: 8] = m_din[p];
                cnt = 0;
                for (int r = 0; r < NR; r++) if (grant_mask[r*NP + p]) cnt++;
                if (cnt > 1) nbad++;
            end
            chk("grant_mask", grant_mask, eg);
            chk("port_busy", port_busy, eb);
            chk("port_owner", port_owner, eo);
            chk("port_din", port_din, ed);
            chk("port_wren", port_wren, m_wren);
            chk("port_del", port_del, m_del);
            chk("proto_err", proto_err, m_err);
            chk("lock_overlap_ports", nbad, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [NP-1:0] m);
        req_mask[r*NP +: NP] = m;
    endtask

    int            st  [NR];
    logic [NP-1:0] msk [NR];
    int            cnt_h [NR];

    initial begin
        #1 arst = 1'b1;
        set_req(0, 4'b0110);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", grant_mask, 16'h0000);
        chk("reset_busy", port_busy, 4'h0);
        chk("reset_owner", port_owner, 8'h00);
        chk("reset_wren", port_wren, 4'h0);
        chk("reset_err", proto_err, 1'b0);
        arst = 1'b0;
        step();
        chk("no_grant_first_edge", grant_mask, 16'h0000);
        step();
        chk("free_grant", grant_mask, 16'h0006);
        chk("free_busy", port_busy, 4'b0110);
        chk("free_owner", port_owner, 8'h00);
        set_req(0, 4'b0000); step();

        // conflict handoff
        set_req(0, 4'b0011); step();
        chk("hold_r0", grant_mask, 16'h0003);
        set_req(1, 4'b0110); step(); step();
        chk("r1_blocked", grant_mask, 16'h0003);
        set_req(0, 4'b0000); step();
        chk("handoff_gap", grant_mask, 16'h0000);
        step();
        chk("handoff_grant", grant_mask, 16'h0060);
        set_req(1, 4'b0000); step();

        // one grant per cycle
        set_req(0, 4'b0001); set_req(1, 4'b0010); step();
        chk("one_per_cycle_e1", grant_mask, 16'h0001);
        step();
        chk("one_per_cycle_e2", grant_mask, 16'h0021);
        chk("model_rr_ptr", m_rr, 2);
        set_req(0, 4'b0000); set_req(1, 4'b0000); step();

        // head-of-line reservation
        set_req(2, 4'b0001); step();
        chk("resv_r2_hold", grant_mask, 16'h0100);
        set_req(0, 4'b0011); set_req(1, 4'b0010); step(); step();
        chk("resv_r1_blocked", grant_mask, 16'h0100);
        set_req(2, 4'b0000); step(); step();
        chk("resv_head_grant", grant_mask, 16'h0003);
        set_req(0, 4'b0000); step(); step();
        chk("resv_r1_grant", grant_mask, 16'h0020);
        set_req(1, 4'b0000); step();

        // datapath steering, non-owner write dropped
        set_req(1, 4'b1000); step();
        chk("dp_grant", grant_mask, 16'h0080);
        req_din = 32'h0000_A53C; req_del = 4'b0010;
        req_wren = 16'h0088;
        step();
        chk("dp_din3", port_din[31:24], 8'hA5);
        chk("dp_wren", port_wren, 4'b1000);
        chk("dp_del", port_del, 4'b1000);
        chk("dp_owner", port_owner, 8'h40);
        req_wren = '0; req_del = '0; set_req(1, 4'b0000); step();

        // growth violation
        set_req(0, 4'b0001); step();
        set_req(0, 4'b0011); step();
        chk("viol_err", proto_err, 1'b1);
        chk("viol_grant", grant_mask, 16'h0001);
        set_req(0, 4'b0001); step();
        chk("viol_err_clear", proto_err, 1'b0);

        // asynchronous reset mid-transfer
        req_din = 32'h0000_0077; req_wren = 16'h0001; step();
        chk("pre_reset_wren", port_wren, 4'b0001);
        #2 arst = 1'b1;
        #1;
        chk("arst_grant", grant_mask, 16'h0000);
        chk("arst_busy", port_busy, 4'h0);
        chk("arst_owner", port_owner, 8'h00);
        chk("arst_dp", {port_din, port_wren, port_del}, 0);
        req_mask = '0; req_wren = '0; req_din = '0;
        step();
        arst = 1'b0;

        // randomized protocol-following traffic
        for (int r = 0; r < NR; r++) begin st[r] = 0; msk[r] = '0; cnt_h[r] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (cyc == 1500) begin
                arst = 1'b1;
                req_mask = '0; req_wren = '0;
                for (int r = 0; r < NR; r++) begin st[r] = 0; msk[r] = '0; end
                step();
                arst = 1'b0;
            end else begin
                for (int r = 0; r < NR; r++) begin
                    bit            rel;
                    logic [NP-1:0] rq;
                    rel = 1'b0;
                    case (st[r])
                        0: if ($urandom_range(0, 2) == 0) begin
                               msk[r] = 4'($urandom_range(1, 15)); st[r] = 1;
                           end
                        1: if (m_lock[r] != 0) begin
                               st[r] = 2; cnt_h[r] = $urandom_range(1, 6);
                           end
                        default: if (cnt_h[r] == 0) begin
                               rel = 1'b1;
                               msk[r] = msk[r] & 4'($urandom_range(0, 15));
                               if (msk[r] == 0) st[r] = 0;
                               else cnt_h[r] = $urandom_range(1, 4);
                           end else cnt_h[r]--;
                    endcase
                    rq = msk[r];
                    if (st[r] == 2 && !rel && $urandom_range(0, 15) == 0)
                        rq = msk[r] | 4'($urandom_range(0, 15));
                    req_mask[r*NP +: NP] = rq;
                    req_wren[r*NP +: NP] = rel ? 4'b0000 : 4'($urandom_range(0, 15));
                    req_din[r*8 +: 8]    = 8'($urandom_range(0, 255));
                    req_del[r]           = 1'($urandom_range(0, 1));
                end
            end
        end
        req_mask = '0; req_wren = '0;
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
